// File: rtl/velocity_estimator_if.sv
// AXI-Stream bundle: tvalid/tdata/tready.
// master drives tvalid/tdata, slave drives tready.
interface velocity_estimator_if #(
  parameter int AXIS_TDATA_WIDTH = 32
);
  logic                        tvalid;
  logic                        tready;
  logic [AXIS_TDATA_WIDTH-1:0] tdata;

  modport master (
    output tvalid,
    output tdata,
    input  tready
  );

  modport slave (
    input  tvalid,
    input  tdata,
    output tready
  );
endinterface

// File: rtl/velocity_estimator.sv
// Decimated velocity: position delta over N accepted beats.
// Ports: aclk, areset, decimation, s_axis (in), m_axis (out),
// overrun (sticky drop flag), drop_count (saturating).
module velocity_estimator #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int DECIM_WIDTH      = 16,
  parameter int DROP_WIDTH       = 16
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic [DECIM_WIDTH-1:0] decimation,
  velocity_estimator_if.slave    s_axis,
  velocity_estimator_if.master   m_axis,
  output logic                   overrun,
  output logic [DROP_WIDTH-1:0]  drop_count
);

  localparam int W = AXIS_TDATA_WIDTH;

  typedef enum logic {
    PRIME,
    RUN
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [DECIM_WIDTH-1:0] cnt_q;
  logic [DECIM_WIDTH-1:0] cnt_d;
  logic [DECIM_WIDTH-1:0] n_lat_q;
  logic [DECIM_WIDTH-1:0] n_lat_d;
  logic [DECIM_WIDTH-1:0] n_eff;
  logic [W-1:0]         pos_q;
  logic [W-1:0]         pos_d;
  logic [W-1:0]         delta;
  logic                 vld_q;
  logic                 vld_d;
  logic [W-1:0]         dat_q;
  logic [W-1:0]         dat_d;
  logic                 ovr_d;
  logic [DROP_WIDTH-1:0] drop_d;
  logic                 close;
  logic                 can_load;

  assign s_axis.tready = 1'b1;
  assign m_axis.tvalid = vld_q;
  assign m_axis.tdata  = dat_q;

  assign n_eff = (decimation == '0) ?
                 DECIM_WIDTH'(1) : decimation;
  assign delta = s_axis.tdata - pos_q;

  // Output slot is free when empty or drained this cycle.
  assign can_load = !vld_q || m_axis.tready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_lat_d = n_lat_q;
    pos_d   = pos_q;
    close   = 1'b0;
    unique case (state_q)
      PRIME: begin
        if (s_axis.tvalid) begin
          pos_d   = s_axis.tdata;
          cnt_d   = '0;
          n_lat_d = n_eff;
          state_d = RUN;
        end
      end
      RUN: begin
        if (s_axis.tvalid) begin
          if (cnt_q == n_lat_q - 1'b1) begin
            close   = 1'b1;
            pos_d   = s_axis.tdata;
            cnt_d   = '0;
            n_lat_d = n_eff;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = PRIME;
    endcase
  end

  always_comb begin
    vld_d  = vld_q;
    dat_d  = dat_q;
    ovr_d  = overrun;
    drop_d = drop_count;
    if (vld_q && m_axis.tready)
      vld_d = 1'b0;
    if (close) begin
      if (can_load) begin
        vld_d = 1'b1;
        dat_d = delta;
      end else begin
        // Pending word wins; the new result is lost.
        ovr_d = 1'b1;
        if (drop_count != '1)
          drop_d = drop_count + 1'b1;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q    <= PRIME;
      cnt_q      <= '0;
      n_lat_q    <= DECIM_WIDTH'(1);
      pos_q      <= '0;
      vld_q      <= 1'b0;
      dat_q      <= '0;
      overrun    <= 1'b0;
      drop_count <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      n_lat_q    <= n_lat_d;
      pos_q      <= pos_d;
      vld_q      <= vld_d;
      dat_q      <= dat_d;
      overrun    <= ovr_d;
      drop_count <= drop_d;
    end
  end

endmodule

// File: tb/tb_velocity_estimator.sv
// Directed bench for velocity_estimator.
// Drives beats after each edge, checks just after the next.
module tb_velocity_estimator;

  logic        aclk = 1'b0;
  logic        areset;
  logic [15:0] decimation;
  logic        overrun;
  logic [15:0] drop_count;

  int checks = 0;
  int errors = 0;

  velocity_estimator_if #(.AXIS_TDATA_WIDTH(32)) s_axis ();
  velocity_estimator_if #(.AXIS_TDATA_WIDTH(32)) m_axis ();

  velocity_estimator #(
    .AXIS_TDATA_WIDTH(32),
    .DECIM_WIDTH(16),
    .DROP_WIDTH(16)
  ) dut (
    .aclk(aclk),
    .areset(areset),
    .decimation(decimation),
    .s_axis(s_axis),
    .m_axis(m_axis),
    .overrun(overrun),
    .drop_count(drop_count)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, got, exp);
    end
  endtask

  task automatic beat(input logic v, input logic [31:0] d);
    s_axis.tvalid = v;
    s_axis.tdata  = d;
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    areset        = 1'b1;
    s_axis.tvalid = 1'b0;
    s_axis.tdata  = '0;
    @(posedge aclk);
    @(posedge aclk);
    #1;
    areset = 1'b0;
  endtask

  initial begin
    areset        = 1'b1;
    decimation    = 16'd4;
    m_axis.tready = 1'b1;
    s_axis.tvalid = 1'b0;
    s_axis.tdata  = '0;
    do_reset();
    chk("rst_vld", 32'(m_axis.tvalid), 32'd0);
    chk("rst_dat", m_axis.tdata, 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    chk("rst_drop", 32'(drop_count), 32'd0);

    // N=4 ramp: output every 4th beat after priming
    for (int i = 0; i <= 12; i++) begin
      beat(1'b1, 32'(i));
      chk($sformatf("n4_vld%0d", i), 32'(m_axis.tvalid),
          32'((i > 0) && (i % 4 == 0)));
      if (i > 0 && i % 4 == 0)
        chk($sformatf("n4_dat%0d", i), m_axis.tdata, 32'd4);
    end
    chk("n4_drop", 32'(drop_count), 32'd0);

    // N=0 treated as 1, signed deltas
    decimation = 16'd0;
    do_reset();
    beat(1'b1, 32'd10);
    chk("n1_prime", 32'(m_axis.tvalid), 32'd0);
    beat(1'b1, 32'd7);
    chk("n1_v0", 32'(m_axis.tvalid), 32'd1);
    chk("n1_d0", m_axis.tdata, 32'hFFFF_FFFD);
    beat(1'b1, 32'd7);
    chk("n1_v1", 32'(m_axis.tvalid), 32'd1);
    chk("n1_d1", m_axis.tdata, 32'd0);
    beat(1'b1, 32'd12);
    chk("n1_v2", 32'(m_axis.tvalid), 32'd1);
    chk("n1_d2", m_axis.tdata, 32'd5);

    // wrap-around
    do_reset();
    beat(1'b1, 32'h7FFF_FFFE);
    beat(1'b1, 32'h8000_0001);
    chk("wrap_v", 32'(m_axis.tvalid), 32'd1);
    chk("wrap_d", m_axis.tdata, 32'd3);

    // backpressure with N=2
    decimation    = 16'd2;
    m_axis.tready = 1'b0;
    do_reset();
    for (int i = 0; i <= 6; i++) begin
      beat(1'b1, 32'(i));
      if (i >= 2) begin
        chk($sformatf("bp_v%0d", i), 32'(m_axis.tvalid), 32'd1);
        chk($sformatf("bp_d%0d", i), m_axis.tdata, 32'd2);
      end
    end
    chk("bp_drop", 32'(drop_count), 32'd2);
    chk("bp_ovr", 32'(overrun), 32'd1);
    m_axis.tready = 1'b1;
    beat(1'b1, 32'd7);
    chk("bp_drain", 32'(m_axis.tvalid), 32'd0);
    beat(1'b1, 32'd8);
    chk("bp_nv", 32'(m_axis.tvalid), 32'd1);
    chk("bp_nd", m_axis.tdata, 32'd2);
    chk("bp_drop2", 32'(drop_count), 32'd2);
    chk("bp_ovr2", 32'(overrun), 32'd1);

    // decimation change mid-window, with an idle gap
    decimation = 16'd3;
    do_reset();
    beat(1'b1, 32'd0);
    beat(1'b1, 32'd1);
    decimation = 16'd5;
    beat(1'b1, 32'd2);
    beat(1'b1, 32'd3);
    chk("dc_v0", 32'(m_axis.tvalid), 32'd1);
    chk("dc_d0", m_axis.tdata, 32'd3);
    beat(1'b1, 32'd4);
    beat(1'b0, 32'd99);
    chk("dc_idle", 32'(m_axis.tvalid), 32'd0);
    beat(1'b1, 32'd5);
    beat(1'b1, 32'd6);
    beat(1'b1, 32'd7);
    chk("dc_early", 32'(m_axis.tvalid), 32'd0);
    beat(1'b1, 32'd8);
    chk("dc_v1", 32'(m_axis.tvalid), 32'd1);
    chk("dc_d1", m_axis.tdata, 32'd5);

    // reset with a pending word
    decimation    = 16'd2;
    m_axis.tready = 1'b0;
    do_reset();
    for (int i = 0; i <= 4; i++) beat(1'b1, 32'(i));
    chk("rp_pend", 32'(m_axis.tvalid), 32'd1);
    chk("rp_drop", 32'(drop_count), 32'd1);
    areset        = 1'b1;
    s_axis.tvalid = 1'b0;
    @(posedge aclk);
    #1;
    chk("rp_vld", 32'(m_axis.tvalid), 32'd0);
    chk("rp_drp0", 32'(drop_count), 32'd0);
    chk("rp_ovr0", 32'(overrun), 32'd0);
    areset        = 1'b0;
    m_axis.tready = 1'b1;
    beat(1'b1, 32'd10);
    beat(1'b1, 32'd11);
    chk("rp_b2", 32'(m_axis.tvalid), 32'd0);
    beat(1'b1, 32'd12);
    chk("rp_b3v", 32'(m_axis.tvalid), 32'd1);
    chk("rp_b3d", m_axis.tdata, 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
